// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings for the instruction fetch unit: PCSrc decisions and fetch FSM states.
package pc_fetch_unit_pkg;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JALR   = 2'b10;

    typedef enum logic [1:0] {
        S_RESET = 2'b00,
        S_FETCH = 2'b01,
        S_WAIT  = 2'b10,
        S_HOLD  = 2'b11
    } if_state_e;

    // The reserved encoding 2'b11 behaves as sequential, so only two codes redirect.
    function automatic logic is_redirect(input logic [1:0] src);
        return (src == PC_BRANCH) || (src == PC_JALR);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-side bus bundle: IMEM request/response channel plus the decode valid/ready channel.
interface pc_fetch_unit_if #(parameter int XLEN = 32);

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_gnt, imem_rvalid, imem_rdata, if_ready
    );

endinterface

// File: rtl/pc_fetch_unit_target_gen.sv
// Redirect target generation from the branch-control PCSrc decision.
module pc_fetch_unit_target_gen
    import pc_fetch_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] target,
    output logic            redirect,
    output logic            misalign_raw
);

    logic [XLEN-1:0] raw;

    always_comb begin
        raw = ex_pc + ex_imm;
        if (pc_src == PC_JALR) begin
            raw = alu_result & ~XLEN'(1);
        end
    end

    // pc_q only holds word-aligned addresses; bit 1 is reported separately as misalign.
    assign target       = raw & ~XLEN'(3);
    assign misalign_raw = raw[1];
    assign redirect     = is_redirect(pc_src);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter owner and single-outstanding IMEM fetcher feeding decode over valid/ready.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  S_RESET | first cycle after reset, no request issued
//  S_FETCH | imem_req asserted at pc_q, waiting for imem_gnt
//  S_WAIT  | request accepted, waiting for imem_rvalid (drop_q marks stale)
//  S_HOLD  | instruction buffered, if_valid high until decode takes it
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] alu_result,
    output logic            flush,
    output logic            misalign,
    pc_fetch_unit_if.master bus
);

    if_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [31:0]     if_instr_q, if_instr_d;
    logic            if_valid_q, if_valid_d;
    logic            drop_q, drop_d;
    logic            misalign_q;

    logic [XLEN-1:0] target;
    logic            redirect;
    logic            misalign_raw;

    pc_fetch_unit_target_gen #(.XLEN(XLEN)) u_target_gen (
        .pc_src       (pc_src),
        .ex_pc        (ex_pc),
        .ex_imm       (ex_imm),
        .alu_result   (alu_result),
        .target       (target),
        .redirect     (redirect),
        .misalign_raw (misalign_raw)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_RESET;
            pc_q       <= RESET_PC;
            if_pc_q    <= '0;
            if_instr_q <= '0;
            if_valid_q <= 1'b0;
            drop_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            if_valid_q <= if_valid_d;
            drop_q     <= drop_d;
            misalign_q <= redirect & misalign_raw;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        if_valid_d = if_valid_q;
        drop_d     = drop_q;

        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                if (bus.imem_gnt) begin
                    if_pc_d = pc_q;
                    pc_d    = pc_q + XLEN'(4);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_FETCH;
                    end else begin
                        if_instr_d = bus.imem_rdata;
                        if_valid_d = 1'b1;
                        state_d    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (bus.if_ready) begin
                    if_valid_d = 1'b0;
                    state_d    = S_FETCH;
                end
            end
            default: state_d = S_RESET;
        endcase

        // A redirect overrides whatever the state decided this cycle.
        if (redirect) begin
            pc_d = target;
            case (state_q)
                S_FETCH: begin
                    if (bus.imem_gnt) begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_WAIT: begin
                    if_instr_d = if_instr_q;
                    if_valid_d = 1'b0;
                    if (bus.imem_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = S_FETCH;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                S_HOLD: begin
                    if_valid_d = 1'b0;
                    state_d    = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign bus.imem_req  = (state_q == S_FETCH);
    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = if_valid_q & ~redirect;
    assign bus.if_instr  = if_instr_q;
    assign bus.if_pc     = if_pc_q;
    assign flush         = redirect;
    assign misalign      = misalign_q;

endmodule
